alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Next-generation ALU controller for the CPU datapath.
- Decodes ALUOp/funct into the ALU operation code and the jr flag, like the current single-cycle controller, but with registered outputs and a valid handshake.
- Sequences multi-cycle operations (mul, optional div) with a busy counter and a stall output toward the PC/IF stage.
- Sits between the main Decoder and the ALU/multiplier.

Parameters:
OP_W, 4, ALUOp_i width; must be >= 4; codes below are zero-extended to OP_W.
FUNCT_W, 6, funct_i width; must be >= 6; codes zero-extended.
MUL_CYCLES, 4, total cycles from accept to result-valid for mul; must be >= 2.
DIV_CYCLES, 8, the same for div; must be >= 2.
DIV_EN, 1, 1 = decode div (funct 011010); 0 = div decodes as illegal.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
valid_i  in  1  ALUOp_i/funct_i carry a new instruction this cycle
ALUOp_i  in  OP_W  operation class from Decoder
funct_i  in  FUNCT_W  R-type funct field
ALUCtrl_o  out  4  registered ALU operation code
Jr_o  out  1  registered jr flag, qualified by valid_o
valid_o  out  1  ALUCtrl_o/Jr_o valid this cycle
stall_o  out  1  multi-cycle op in progress; upstream must hold
mc_done_o  out  1  one-cycle pulse: multi-cycle result ready
illegal_o  out  1  registered; accepted instruction decoded to default

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: state IDLE, counter 0, ALUCtrl_o=4'b1111, Jr_o=0, valid_o=0, stall_o=0, mc_done_o=0, illegal_o=0. Reset wins over any simultaneous valid_i, including mid-BUSY; the in-flight op is dropped with no done pulse.
- Decode (priority in this order; R means ALUOp=0010 plus the listed funct):
  - ALUOp 0000 / 0001 / 0011 -> 0010
  - R 100001 -> 0010; R 100011 -> 0011; R 100100 -> 0000; R 100101 -> 0001
  - ALUOp 0111 -> 0001; R 101010 or ALUOp 1000 -> 1010
  - R 000011 -> 1000; R 000111 -> 1001
  - ALUOp 0100 -> 0110; 0101 -> 0111; 1011 -> 0011; 1101 -> 0011; 0110 -> 1100
  - R 011000 (mul) -> 1101; R 011010 (div, DIV_EN=1) -> 1110
  - R 001000 (jr) -> Jr=1, ALUCtrl 1111, not illegal
  - anything else -> 1111 with illegal
- States: IDLE, BUSY, DONE.
- Accept condition: valid_i=1 in IDLE or DONE. Otherwise valid_i is ignored; upstream holds it because stall_o=1.
- Single-cycle op accepted at edge t:
  - at t+1: valid_o=1, ALUCtrl_o/Jr_o/illegal_o = decode; state IDLE.
  - Latency 1 cycle; back-to-back accepts give valid_o on consecutive cycles.
- mul/div accepted at edge t:
  - state BUSY, cnt=N-1, where N = MUL_CYCLES or DIV_CYCLES.
  - ALUCtrl_o = op code from t+1 and held throughout; valid_o=0, stall_o=1 while in BUSY.
  - In BUSY: cnt==1 -> DONE, else cnt--. So stall_o is high for cycles t+1..t+N-1.
  - DONE (cycle t+N): valid_o=1, mc_done_o=1, stall_o=0, ALUCtrl_o still the op code.
  - DONE with valid_i=1 accepts the next op at the same edge; otherwise DONE -> IDLE.
- Cycles without an accept: valid_o=0, Jr_o=0, illegal_o=0; ALUCtrl_o holds its last value.
- Jr_o and illegal_o are never 1 while valid_o=0.
- stall_o depends only on state and is never combinational from valid_i.
- Counter width: clog2(max(MUL_CYCLES, DIV_CYCLES)). No wrap: cnt never decrements below 1.

Test Plan:
- Reset: assert rst_i 2 cycles with valid_i=1, ALUOp=0010, funct=011000 -> ALUCtrl_o=1111, all other outputs 0, no BUSY entry.
- Single-cycle stream: valid_i=1 for 3 cycles with addu, sub, then ALUOp=0110 -> valid_o on 3 consecutive cycles, ALUCtrl_o 0010, 0011, 1100; stall_o=0 throughout.
- mul, MUL_CYCLES=4: accept at t -> stall_o=1 at t+1..t+3; at t+4 valid_o=1, mc_done_o=1, ALUCtrl_o=1101; a sub held on valid_i during the stall is accepted at t+4 and appears with valid_o=1, ALUCtrl_o=0011 at t+5.
- div: DIV_EN=1, DIV_CYCLES=8 -> 7 stall cycles, then done with ALUCtrl_o=1110. DIV_EN=0 -> one-cycle valid_o, ALUCtrl_o=1111, illegal_o=1, no stall.
- jr and illegal: funct 001000 -> valid_o=1, Jr_o=1, ALUCtrl_o=1111, illegal_o=0. ALUOp=1111 -> illegal_o=1, Jr_o=0.
- Reset mid-BUSY: assert rst_i at the second BUSY cycle -> next cycle state IDLE, stall_o=0; mc_done_o never pulses.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU controller: decodes ALUOp/funct into a registered ALU op code, jr flag and illegal flag.
// Latency: 1 cycle for single-cycle ops. mul/div report valid_o with mc_done_o N cycles after accept.
// Backpressure: stall_o is high while a mul/div is in BUSY. valid_i is ignored then, and upstream holds it.
// Ports: clk_i/rst_i (sync, active-high); valid_i, ALUOp_i, funct_i in;
//        ALUCtrl_o, Jr_o, valid_o, stall_o, mc_done_o, illegal_o out.
module alu_ctrl_seq #(
  parameter int OP_W       = 4,
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter bit DIV_EN     = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [3:0]         ALUCtrl_o,
  output logic               Jr_o,
  output logic               valid_o,
  output logic               stall_o,
  output logic               mc_done_o,
  output logic               illegal_o
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [OP_W-1:0] OP_R = OP_W'(4'b0010);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       ctrl_n;
  logic             jr_n, ill_n, valid_n, done_n;

  logic [3:0] dec_ctrl;
  logic       dec_jr, dec_ill, dec_mul, dec_div, is_r;

  function automatic logic op_is(input logic [OP_W-1:0] op, input logic [3:0] code);
    return op == OP_W'(code);
  endfunction

  function automatic logic fn_is(input logic [FUNCT_W-1:0] fn, input logic [5:0] code);
    return fn == FUNCT_W'(code);
  endfunction

  // Priority decode. R-type entries only match when ALUOp selects R-format.
  always_comb begin
    dec_ctrl = 4'b1111;
    dec_jr   = 1'b0;
    dec_ill  = 1'b0;
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    is_r     = (ALUOp_i == OP_R);
    if (op_is(ALUOp_i, 4'b0000) || op_is(ALUOp_i, 4'b0001) || op_is(ALUOp_i, 4'b0011))
      dec_ctrl = 4'b0010;
    else if (is_r && fn_is(funct_i, 6'b100001)) dec_ctrl = 4'b0010;
    else if (is_r && fn_is(funct_i, 6'b100011)) dec_ctrl = 4'b0011;
    else if (is_r && fn_is(funct_i, 6'b100100)) dec_ctrl = 4'b0000;
    else if (is_r && fn_is(funct_i, 6'b100101)) dec_ctrl = 4'b0001;
    else if (op_is(ALUOp_i, 4'b0111))           dec_ctrl = 4'b0001;
    else if ((is_r && fn_is(funct_i, 6'b101010)) || op_is(ALUOp_i, 4'b1000))
      dec_ctrl = 4'b1010;
    else if (is_r && fn_is(funct_i, 6'b000011)) dec_ctrl = 4'b1000;
    else if (is_r && fn_is(funct_i, 6'b000111)) dec_ctrl = 4'b1001;
    else if (op_is(ALUOp_i, 4'b0100))           dec_ctrl = 4'b0110;
    else if (op_is(ALUOp_i, 4'b0101))           dec_ctrl = 4'b0111;
    else if (op_is(ALUOp_i, 4'b1011))           dec_ctrl = 4'b0011;
    else if (op_is(ALUOp_i, 4'b1101))           dec_ctrl = 4'b0011;
    else if (op_is(ALUOp_i, 4'b0110))           dec_ctrl = 4'b1100;
    else if (is_r && fn_is(funct_i, 6'b011000)) begin
      dec_ctrl = 4'b1101;
      dec_mul  = 1'b1;
    end else if (DIV_EN && is_r && fn_is(funct_i, 6'b011010)) begin
      dec_ctrl = 4'b1110;
      dec_div  = 1'b1;
    end else if (is_r && fn_is(funct_i, 6'b001000)) begin
      dec_jr   = 1'b1;
    end else begin
      dec_ill  = 1'b1;
    end
  end

  // Next-state and output logic. Jr/illegal/valid default low, and ALUCtrl holds its value.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ctrl_n  = ALUCtrl_o;
    jr_n    = 1'b0;
    ill_n   = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (valid_i) begin
          ctrl_n = dec_ctrl;
          if (dec_mul || dec_div) begin
            state_n = BUSY;
            cnt_n   = dec_mul ? MUL_LOAD : DIV_LOAD;
          end else begin
            valid_n = 1'b1;
            jr_n    = dec_jr;
            ill_n   = dec_ill;
          end
        end
      end
      BUSY: begin
        // Leave at cnt==1, so the counter never goes below 1.
        if (cnt == CNT_ONE) begin
          state_n = DONE;
          valid_n = 1'b1;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      ALUCtrl_o <= 4'b1111;
      Jr_o      <= 1'b0;
      illegal_o <= 1'b0;
      valid_o   <= 1'b0;
      mc_done_o <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ALUCtrl_o <= ctrl_n;
      Jr_o      <= jr_n;
      illegal_o <= ill_n;
      valid_o   <= valid_n;
      mc_done_o <= done_n;
    end
  end

  // stall_o comes only from the state register, so it has no combinational path from valid_i.
  assign stall_o = (state == BUSY);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq. Instance a has DIV_EN=1 and instance b has DIV_EN=0.
// Both instances share stimulus. Inputs change #1 after the rising edge, and outputs are checked at that point.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [3:0] op  = 4'b0000;
  logic [5:0] fn  = 6'b000000;

  logic [3:0] a_ctrl, b_ctrl;
  logic       a_jr, a_vld, a_stall, a_done, a_ill;
  logic       b_jr, b_vld, b_stall, b_done, b_ill;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.OP_W(4), .FUNCT_W(6), .MUL_CYCLES(4), .DIV_CYCLES(8), .DIV_EN(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .ALUOp_i(op), .funct_i(fn),
    .ALUCtrl_o(a_ctrl), .Jr_o(a_jr), .valid_o(a_vld), .stall_o(a_stall),
    .mc_done_o(a_done), .illegal_o(a_ill)
  );

  alu_ctrl_seq #(.OP_W(4), .FUNCT_W(6), .MUL_CYCLES(4), .DIV_CYCLES(8), .DIV_EN(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .ALUOp_i(op), .funct_i(fn),
    .ALUCtrl_o(b_ctrl), .Jr_o(b_jr), .valid_o(b_vld), .stall_o(b_stall),
    .mc_done_o(b_done), .illegal_o(b_ill)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [5:0] f);
    vld = v;
    op  = o;
    fn  = f;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Reset is held for two cycles while a mul is presented.
    drive(1'b1, 4'b0010, 6'b011000);
    step();
    step();
    chk("rst_ctrl",  {4'h0, a_ctrl}, 8'h0f);
    chk("rst_vld",   {7'h0, a_vld},  8'h00);
    chk("rst_stall", {7'h0, a_stall}, 8'h00);
    chk("rst_done",  {7'h0, a_done}, 8'h00);
    chk("rst_jr",    {7'h0, a_jr},   8'h00);
    chk("rst_ill",   {7'h0, a_ill},  8'h00);
    rst = 1'b0;
    drive(1'b0, 4'b0000, 6'b000000);
    step();
    chk("rst_nobusy", {7'h0, a_stall}, 8'h00);

    // A single-cycle stream of addu, sub and then ALUOp 0110.
    drive(1'b1, 4'b0010, 6'b100001);
    step();
    chk("s1_vld", {7'h0, a_vld}, 8'h01);
    chk("s1_ctrl", {4'h0, a_ctrl}, 8'h02);
    chk("s1_stall", {7'h0, a_stall}, 8'h00);
    drive(1'b1, 4'b0010, 6'b100011);
    step();
    chk("s2_vld", {7'h0, a_vld}, 8'h01);
    chk("s2_ctrl", {4'h0, a_ctrl}, 8'h03);
    chk("s2_stall", {7'h0, a_stall}, 8'h00);
    drive(1'b1, 4'b0110, 6'b000000);
    step();
    chk("s3_vld", {7'h0, a_vld}, 8'h01);
    chk("s3_ctrl", {4'h0, a_ctrl}, 8'h0c);
    chk("s3_stall", {7'h0, a_stall}, 8'h00);
    drive(1'b0, 4'b0000, 6'b000000);
    step();
    chk("idle_vld", {7'h0, a_vld}, 8'h00);
    chk("idle_hold", {4'h0, a_ctrl}, 8'h0c);

    // mul: stall at t+1..t+3, done at t+4, and the held sub appears at t+5.
    drive(1'b1, 4'b0010, 6'b011000);
    step();
    drive(1'b1, 4'b0010, 6'b100011);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) step();
      chk($sformatf("mul_stall%0d", i), {7'h0, a_stall}, 8'h01);
      chk($sformatf("mul_vld%0d", i), {7'h0, a_vld}, 8'h00);
      chk($sformatf("mul_ctrl%0d", i), {4'h0, a_ctrl}, 8'h0d);
    end
    step();
    chk("mul_done", {7'h0, a_done}, 8'h01);
    chk("mul_dvld", {7'h0, a_vld}, 8'h01);
    chk("mul_dctrl", {4'h0, a_ctrl}, 8'h0d);
    chk("mul_dstall", {7'h0, a_stall}, 8'h00);
    step();
    chk("sub_vld", {7'h0, a_vld}, 8'h01);
    chk("sub_ctrl", {4'h0, a_ctrl}, 8'h03);
    chk("sub_nodone", {7'h0, a_done}, 8'h00);
    drive(1'b0, 4'b0000, 6'b000000);
    step();

    // div: instance a has 7 stall cycles, and instance b treats div as illegal.
    drive(1'b1, 4'b0010, 6'b011010);
    step();
    drive(1'b0, 4'b0000, 6'b000000);
    chk("b_div_vld", {7'h0, b_vld}, 8'h01);
    chk("b_div_ctrl", {4'h0, b_ctrl}, 8'h0f);
    chk("b_div_ill", {7'h0, b_ill}, 8'h01);
    chk("b_div_stall", {7'h0, b_stall}, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) step();
      chk($sformatf("div_stall%0d", i), {7'h0, a_stall}, 8'h01);
      chk($sformatf("div_ctrl%0d", i), {4'h0, a_ctrl}, 8'h0e);
    end
    step();
    chk("div_done", {7'h0, a_done}, 8'h01);
    chk("div_vld", {7'h0, a_vld}, 8'h01);
    chk("div_ctrl", {4'h0, a_ctrl}, 8'h0e);
    chk("div_stall", {7'h0, a_stall}, 8'h00);
    step();
    chk("div_idle", {7'h0, a_vld}, 8'h00);

    // jr, then an illegal ALUOp, then an idle cycle.
    drive(1'b1, 4'b0010, 6'b001000);
    step();
    chk("jr_vld", {7'h0, a_vld}, 8'h01);
    chk("jr_jr", {7'h0, a_jr}, 8'h01);
    chk("jr_ctrl", {4'h0, a_ctrl}, 8'h0f);
    chk("jr_ill", {7'h0, a_ill}, 8'h00);
    drive(1'b1, 4'b1111, 6'b000000);
    step();
    chk("ill_ill", {7'h0, a_ill}, 8'h01);
    chk("ill_jr", {7'h0, a_jr}, 8'h00);
    chk("ill_vld", {7'h0, a_vld}, 8'h01);
    chk("ill_ctrl", {4'h0, a_ctrl}, 8'h0f);
    drive(1'b0, 4'b0000, 6'b000000);
    step();
    chk("post_jr", {7'h0, a_jr}, 8'h00);
    chk("post_ill", {7'h0, a_ill}, 8'h00);

    // A few more decodes.
    vecs[0] = '{op: 4'b1000, fn: 6'b000000, ctrl: 4'b1010};
    vecs[1] = '{op: 4'b0010, fn: 6'b000111, ctrl: 4'b1001};
    vecs[2] = '{op: 4'b0111, fn: 6'b000000, ctrl: 4'b0001};
    vecs[3] = '{op: 4'b0010, fn: 6'b100100, ctrl: 4'b0000};
    vecs[4] = '{op: 4'b0101, fn: 6'b000000, ctrl: 4'b0111};
    vecs[5] = '{op: 4'b0010, fn: 6'b101010, ctrl: 4'b1010};
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].fn);
      step();
      chk($sformatf("dec%0d", i), {4'h0, a_ctrl}, {4'h0, vecs[i].ctrl});
      chk($sformatf("dec%0d_ill", i), {7'h0, a_ill}, 8'h00);
    end
    drive(1'b0, 4'b0000, 6'b000000);
    step();

    // Reset at the second BUSY cycle drops the mul with no done pulse.
    drive(1'b1, 4'b0010, 6'b011000);
    step();
    drive(1'b0, 4'b0000, 6'b000000);
    chk("mr_busy1", {7'h0, a_stall}, 8'h01);
    step();
    chk("mr_busy2", {7'h0, a_stall}, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_stall", {7'h0, a_stall}, 8'h00);
    chk("mr_vld", {7'h0, a_vld}, 8'h00);
    chk("mr_ctrl", {4'h0, a_ctrl}, 8'h0f);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("mr_nodone%0d", i), {7'h0, a_done}, 8'h00);
      chk($sformatf("mr_idle%0d", i), {7'h0, a_stall}, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
